// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry in-order result FIFO feeding the register file, plus Z/N/C/V flags.
// Define WB_FORWARD_EN to add a forwarding lookup over the buffered entries.
module alu_writeback_stage #(
    parameter int WORD_SIZE  = 19,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_opcode,
    input  logic [WORD_SIZE-1:0]  in_result,
    input  logic                  in_carry,
    input  logic                  in_ovf,
    input  logic [REG_ADDR_W-1:0] in_dest,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WORD_SIZE-1:0]  rf_wdata,
    input  logic                  rf_ready,
    output logic [3:0]            flags,
    output logic [1:0]            occupancy,
    output logic [15:0]           retire_count
`ifdef WB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0] fwd_addr,
    output logic                  fwd_hit,
    output logic [WORD_SIZE-1:0]  fwd_data
`endif
);

    localparam logic [4:0] OP_NOP = 5'h1F;

    logic [WORD_SIZE-1:0]  res_mem  [2];
    logic [REG_ADDR_W-1:0] dest_mem [2];
    logic [1:0]            carry_mem;
    logic [1:0]            ovf_mem;
    logic [1:0]            keep_flags_mem;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  tail_ptr;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;

    // A NOP is handshaken like any result but never enters the FIFO.
    assign in_ready  = (count != 2'd2) && !rst;
    assign push      = in_valid && in_ready && (in_opcode != OP_NOP);
    assign rf_we     = (count != 2'd0) && !rst;
    assign pop       = rf_we && rf_ready;
    assign rf_waddr  = dest_mem[rd_ptr];
    assign rf_wdata  = res_mem[rd_ptr];
    assign occupancy = count;
    assign tail_ptr  = ~rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr]        <= in_result;
            dest_mem[wr_ptr]       <= in_dest;
            carry_mem[wr_ptr]      <= in_carry;
            ovf_mem[wr_ptr]        <= in_ovf;
            keep_flags_mem[wr_ptr] <= in_opcode[4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            flags        <= 4'b0000;
            retire_count <= 16'h0000;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr       <= ~rd_ptr;
                retire_count <= retire_count + 16'd1;
                if (!keep_flags_mem[rd_ptr]) begin
                    flags <= {rf_wdata == '0, rf_wdata[WORD_SIZE-1],
                              carry_mem[rd_ptr], ovf_mem[rd_ptr]};
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    // Head is checked first so a matching younger tail entry overrides it.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (count != 2'd0 && dest_mem[rd_ptr] == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = res_mem[rd_ptr];
        end
        if (count == 2'd2 && dest_mem[tail_ptr] == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = res_mem[tail_ptr];
        end
    end
`else
    logic unused_tail;
    assign unused_tail = tail_ptr;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage; register-file writes are checked against an expected queue.
module tb_alu_writeback_stage;

    localparam int W = 19;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   in_opcode = '0;
    logic [W-1:0] in_result = '0;
    logic         in_carry = 1'b0;
    logic         in_ovf = 1'b0;
    logic [A-1:0] in_dest = '0;
    logic         rf_we;
    logic [A-1:0] rf_waddr;
    logic [W-1:0] rf_wdata;
    logic         rf_ready = 1'b0;
    logic [3:0]   flags;
    logic [1:0]   occupancy;
    logic [15:0]  retire_count;
`ifdef WB_FORWARD_EN
    logic [A-1:0] fwd_addr = '0;
    logic         fwd_hit;
    logic [W-1:0] fwd_data;
`endif

    int n_total = 0;
    int n_bad   = 0;
    logic [A+W-1:0] exp_q [$];

    alu_writeback_stage #(.WORD_SIZE(W), .REG_ADDR_W(A)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_result(in_result), .in_carry(in_carry), .in_ovf(in_ovf), .in_dest(in_dest),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
        .flags(flags), .occupancy(occupancy), .retire_count(retire_count)
`ifdef WB_FORWARD_EN
        , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    // Every accepted write is checked against the oldest expected entry.
    always @(negedge clk) begin
        if (rf_we === 1'b1 && rf_ready === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", rf_waddr, rf_wdata);
            end else begin
                logic [A+W-1:0] exp_w;
                exp_w = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== exp_w) begin
                    n_bad++;
                    $display("FAIL write_order: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             rf_waddr, rf_wdata, exp_w[A+W-1:W], exp_w[W-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [W-1:0] res, input logic c,
                         input logic v, input logic [A-1:0] d);
        in_valid  = 1'b1;
        in_opcode = op;
        in_result = res;
        in_carry  = c;
        in_ovf    = v;
        in_dest   = d;
        if (op != 5'h1F) exp_q.push_back({d, res});
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rf_ready = 1'b0;
        step();
        step();
        n_total++;
        if (in_ready !== 1'b0 || rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs: got in_ready=%b rf_we=%b, required 0 0", in_ready, rf_we);
        end
        n_total++;
        if ({occupancy, flags, retire_count} !== 22'h0) begin
            n_bad++;
            $display("FAIL reset_state: got occ=%0d flags=%b retire=%0h, required 0 0000 0",
                     occupancy, flags, retire_count);
        end
        rst = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: got in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        rf_ready = 1'b1;
        drive(5'h00, 19'h00005, 1'b0, 1'b0, 4'd3);
        n_total++;
        if (rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_latency: got rf_we=%b in push cycle, required 0", rf_we);
        end
        step();
        idle();
        n_total++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 19'h00005) begin
            n_bad++;
            $display("FAIL basic_write: got we=%b addr=%0h data=%0h, required 1 3 5", rf_we, rf_waddr, rf_wdata);
        end
        step();
        n_total++;
        if (flags !== 4'b0000 || retire_count !== 16'd1 || occupancy !== 2'd0) begin
            n_bad++;
            $display("FAIL basic_after: got flags=%b retire=%0d occ=%0d, required 0000 1 0",
                     flags, retire_count, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        rf_ready = 1'b0;
        drive(5'h00, 19'h00001, 1'b0, 1'b0, 4'd1);
        step();
        drive(5'h00, 19'h00002, 1'b0, 1'b0, 4'd2);
        step();
        drive(5'h00, 19'h00003, 1'b0, 1'b0, 4'd9);
        n_total++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
            n_bad++;
            $display("FAIL b2b_full: got in_ready=%b occ=%0d, required 0 2", in_ready, occupancy);
        end
        step();
        n_total++;
        if (occupancy !== 2'd2 || rf_waddr !== 4'd1 || rf_wdata !== 19'h00001) begin
            n_bad++;
            $display("FAIL b2b_hold: got occ=%0d addr=%0h data=%0h, required 2 1 1", occupancy, rf_waddr, rf_wdata);
        end
        rf_ready = 1'b1;
        step();
        n_total++;
        if (occupancy !== 2'd1) begin
            n_bad++;
            $display("FAIL b2b_pop1: got occ=%0d, required 1", occupancy);
        end
        step();
        idle();
        n_total++;
        if (occupancy !== 2'd1) begin
            n_bad++;
            $display("FAIL b2b_pushpop: got occ=%0d, required 1", occupancy);
        end
        step();
        n_total++;
        if (occupancy !== 2'd0 || retire_count !== 16'd4 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain: got occ=%0d retire=%0d pending=%0d, required 0 4 0",
                     occupancy, retire_count, exp_q.size());
        end
    endtask

    task automatic test_flags();
        rf_ready = 1'b1;
        drive(5'h01, 19'h40000, 1'b1, 1'b1, 4'd4);
        step();
        idle();
        step();
        n_total++;
        if (flags !== 4'b0111) begin
            n_bad++;
            $display("FAIL flags_sub: got %b, required 0111", flags);
        end
        drive(5'h01, 19'h00000, 1'b0, 1'b0, 4'd5);
        step();
        idle();
        step();
        n_total++;
        if (flags !== 4'b1000) begin
            n_bad++;
            $display("FAIL flags_zero: got %b, required 1000", flags);
        end
        drive(5'h12, 19'h7FFFF, 1'b1, 1'b0, 4'd6);
        step();
        idle();
        step();
        n_total++;
        if (flags !== 4'b1000 || retire_count !== 16'd7) begin
            n_bad++;
            $display("FAIL flags_keep: got flags=%b retire=%0d, required 1000 7", flags, retire_count);
        end
    endtask

    task automatic test_nop();
        rf_ready = 1'b1;
        drive(5'h1F, 19'h00009, 1'b1, 1'b1, 4'd7);
        step();
        idle();
        n_total++;
        if (occupancy !== 2'd0 || rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL nop_discard: got occ=%0d we=%b, required 0 0", occupancy, rf_we);
        end
        step();
        n_total++;
        if (retire_count !== 16'd7 || flags !== 4'b1000) begin
            n_bad++;
            $display("FAIL nop_state: got retire=%0d flags=%b, required 7 1000", retire_count, flags);
        end
    endtask

`ifdef WB_FORWARD_EN
    task automatic test_forward();
        rf_ready = 1'b0;
        drive(5'h00, 19'h00011, 1'b0, 1'b0, 4'd2);
        step();
        drive(5'h00, 19'h00022, 1'b0, 1'b0, 4'd2);
        step();
        idle();
        fwd_addr = 4'd2;
        #1;
        n_total++;
        if (fwd_hit !== 1'b1 || fwd_data !== 19'h00022) begin
            n_bad++;
            $display("FAIL fwd_young: got hit=%b data=%0h, required 1 22", fwd_hit, fwd_data);
        end
        fwd_addr = 4'd5;
        #1;
        n_total++;
        if (fwd_hit !== 1'b0 || fwd_data !== 19'h0) begin
            n_bad++;
            $display("FAIL fwd_miss: got hit=%b data=%0h, required 0 0", fwd_hit, fwd_data);
        end
        rf_ready = 1'b1;
        step();
        step();
    endtask
`endif

    task automatic test_reset_mid();
        rf_ready = 1'b0;
        drive(5'h00, 19'h00111, 1'b1, 1'b0, 4'd1);
        step();
        drive(5'h00, 19'h00222, 1'b0, 1'b1, 4'd2);
        step();
        n_total++;
        if (occupancy !== 2'd2) begin
            n_bad++;
            $display("FAIL rmid_full: got occ=%0d, required 2", occupancy);
        end
        rst = 1'b1;
        in_valid = 1'b1;
        in_opcode = 5'h00;
        in_result = 19'h00333;
        in_dest = 4'd3;
        #1;
        n_total++;
        if (rf_we !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_gate: got we=%b in_ready=%b, required 0 0", rf_we, in_ready);
        end
        step();
        rst = 1'b0;
        idle();
        exp_q.delete();
        n_total++;
        if (occupancy !== 2'd0 || rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_clear: got occ=%0d we=%b, required 0 0", occupancy, rf_we);
        end
        rf_ready = 1'b1;
        repeat (3) step();
        n_total++;
        if (occupancy !== 2'd0 || retire_count !== 16'd0 || flags !== 4'b0000) begin
            n_bad++;
            $display("FAIL rmid_after: got occ=%0d retire=%0d flags=%b, required 0 0 0000",
                     occupancy, retire_count, flags);
        end
    endtask

    task automatic test_wrap();
        rf_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            drive(5'($urandom_range(0, 30)), W'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            step();
        end
        idle();
        step();
        n_total++;
        if (retire_count !== 16'hFFFF || occupancy !== 2'd0) begin
            n_bad++;
            $display("FAIL wrap_preload: got retire=%0h occ=%0d, required ffff 0", retire_count, occupancy);
        end
        drive(5'h1F, 19'h00042, 1'b0, 1'b0, 4'd8);
        step();
        idle();
        step();
        n_total++;
        if (retire_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_nop: got retire=%0h, required ffff", retire_count);
        end
        drive(5'h00, 19'h00001, 1'b0, 1'b0, 4'd1);
        step();
        idle();
        step();
        n_total++;
        if (retire_count !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap_rollover: got retire=%0h, required 0", retire_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flags();
        test_nop();
`ifdef WB_FORWARD_EN
        test_forward();
`endif
        test_reset_mid();
        test_wrap();
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL final_drain: got pending=%0d, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
